demux_1to4_buf: RTL and testbench
=================================

DEMUX_1TO4_BUF -- requirements
Module: demux_1to4_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, entries per channel buffer (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  WIDTH  word to be routed.
REQ-006 SHALL have port in_sel  input  2  destination channel (0..3).
REQ-007 SHALL have port in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 SHALL have port in_ready  output  1  selected channel can accept a word.
REQ-009 SHALL have port out_data  output  4*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid  output  4  bit k: channel k head word valid.
REQ-011 SHALL have port out_ready  input  4  bit k: consumer k takes head word.
REQ-012 SHALL have port occ  output  8  channel k occupancy at bits [2k+1:2k], saturating at 3.
REQ-013 SHALL have port drop_cnt  output  16  count of cycles with in_valid=1 and in_ready=0.

Function
REQ-014 SHALL implement four independent FIFOs of DEPTH entries, one per channel, preserving per-channel order.
REQ-015 SHALL compute in_ready combinationally as NOT full[in_sel]; no dependence on out_ready (no pass-through).
REQ-016 SHALL push {in_data} into FIFO[in_sel] exactly when in_valid=1 and in_ready=1.
REQ-017 SHALL pop FIFO[k] exactly when out_valid[k]=1 and out_ready[k]=1.
REQ-018 SHALL drive out_valid[k]=1 iff FIFO[k] is non-empty, and out_data slice k = FIFO[k] head entry.
REQ-019 SHALL drive out_data slice k = 0 when FIFO[k] is empty.
REQ-020 SHALL give latency of one cycle: word pushed at edge N is visible on out_data/out_valid after edge N.
REQ-021 SHALL, on simultaneous push and pop of the same non-full, non-empty channel, keep occupancy unchanged and advance head.
REQ-022 SHALL, on simultaneous push and pop of an empty channel, not forward; pushed word appears next cycle, pop ignored (out_valid was 0).
REQ-023 SHALL block push to a full channel even if that channel pops in the same cycle.
REQ-024 SHALL leave channels other than in_sel unaffected by input activity; pops on any channels may occur concurrently.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; occupancy counter width log2(DEPTH)+1.
REQ-026 SHALL report occ slice k = min(occupancy_k, 3).
REQ-027 SHALL increment drop_cnt by 1 each cycle with in_valid=1 and in_ready=0, wrapping 0xFFFF -> 0x0000.
REQ-028 SHALL ignore in_data and in_sel when in_valid=0 (no state change, no drop count).

Reset
REQ-029 SHALL, while rst=1 at a clock edge, empty all FIFOs: out_valid=4'b0000, out_data=0, occ=8'h00, drop_cnt=16'h0000.
REQ-030 SHALL drive in_ready=1 during and after reset until a channel fills.
REQ-031 SHALL, on rst asserted mid-operation, discard all buffered words and ignore same-cycle push/pop.
REQ-032 SHALL not require storage RAM contents to be cleared; only pointers, counts and outputs.

Verification
REQ-033 Route: after reset push A=0x0000 sel0, B=0x00FF sel1, C=0xFF00 sel2, D=0xFFFF sel3, out_ready=0 -> out_valid=4'b1111, slices {0xFFFF,0xFF00,0x00FF,0x0000} (k=3..0), occ=8'h55.
REQ-034 Fill/stall: DEPTH=2, push 0x0001,0x0002,0x0003 to sel2, out_ready=0 -> third cycle in_ready=0, drop_cnt=1, occ[5:4]=2, head 0x0001.
REQ-035 Order/drain: from REQ-034 state assert out_ready[2] two cycles -> outputs 0x0001 then 0x0002, then out_valid[2]=0, out_data slice 2=0.
REQ-036 Concurrent: channel 1 holds one word 0x00AA; same cycle push 0x00BB sel1 and out_ready[1]=1 -> next cycle head 0x00BB, occ[3:2]=1.
REQ-037 Empty push/pop: channel 0 empty, push 0x1234 sel0 with out_ready[0]=1 -> next cycle out_valid[0]=1, slice 0=0x1234.
REQ-038 Reset mid-run: all channels holding data, drop_cnt=5, assert rst one cycle with in_valid=1 -> out_valid=0, occ=0, drop_cnt=0, in_ready=1.

Source files
------------

// File: rtl/demux_1to4_buf.sv
// demux_1to4_buf: routes one input word per cycle to one of four
// independent per-channel FIFOs, each drained by its own consumer.
module demux_1to4_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [7:0]         occ,
    output logic [15:0]        drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [3:0] full;
    logic [3:0] push;
    logic [3:0] pop;

    // Readiness depends only on the selected channel's fill state, never on out_ready.
    always_comb begin
        in_ready = ~full[in_sel];
    end

    // Count cycles where a valid word could not be accepted; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (in_valid && !in_ready) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_chan
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [CW-1:0]    count;

        assign full[k]      = (count == CW'(DEPTH));
        assign out_valid[k] = (count != '0);
        assign push[k]      = in_valid && in_ready && (in_sel == 2'(k));
        assign pop[k]       = out_valid[k] && out_ready[k];

        // Storage write; contents need no reset since count gates visibility.
        always_ff @(posedge clk) begin
            if (!rst && push[k]) begin
                mem[wr_ptr] <= in_data;
            end
        end

        // Pointer and occupancy bookkeeping; reset discards buffered words.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[k]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push[k], pop[k]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // Head word presented only while the channel holds data; saturating occupancy.
        always_comb begin
            out_data[k*WIDTH +: WIDTH] = out_valid[k] ? mem[rd_ptr] : '0;
            occ[2*k +: 2] = (count > CW'(3)) ? 2'd3 : count[1:0];
        end
    end

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Directed self-checking bench for demux_1to4_buf (WIDTH=16, DEPTH=2).
module tb_demux_1to4_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  occ;
    logic [15:0] drop_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_1to4_buf #(.WIDTH(16), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .occ(occ), .drop_cnt(drop_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 16'h0; out_ready = 4'b0;
        tick(); tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL rst_out_valid got=%b exp=0000", out_valid); end
        checks++; if (out_data !== 64'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (occ !== 8'h00) begin failures++; $display("FAIL rst_occ got=%h exp=00", occ); end
        checks++; if (drop_cnt !== 16'h0) begin failures++; $display("FAIL rst_drop got=%h exp=0000", drop_cnt); end
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_route;
        in_valid = 1'b1;
        in_sel = 2'd0; in_data = 16'h0000; tick();
        in_sel = 2'd1; in_data = 16'h00FF; tick();
        in_sel = 2'd2; in_data = 16'hFF00; tick();
        in_sel = 2'd3; in_data = 16'hFFFF; tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b1111) begin failures++; $display("FAIL route_valid got=%b exp=1111", out_valid); end
        checks++; if (out_data !== 64'hFFFF_FF00_00FF_0000) begin failures++; $display("FAIL route_data got=%h exp=ffffff0000ff0000", out_data); end
        checks++; if (occ !== 8'h55) begin failures++; $display("FAIL route_occ got=%h exp=55", occ); end
        out_ready = 4'b1111; tick(); out_ready = 4'b0000;
        checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL route_drain got=%b exp=0000", out_valid); end
    endtask

    task automatic test_fill;
        in_valid = 1'b1; in_sel = 2'd2;
        in_data = 16'h0001; tick();
        in_data = 16'h0002; tick();
        in_data = 16'h0003; #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL fill_drop got=%0d exp=1", drop_cnt); end
        checks++; if (occ[5:4] !== 2'd2) begin failures++; $display("FAIL fill_occ got=%0d exp=2", occ[5:4]); end
        checks++; if (out_data[47:32] !== 16'h0001) begin failures++; $display("FAIL fill_head got=%h exp=0001", out_data[47:32]); end
    endtask

    task automatic test_drain;
        out_ready = 4'b0100; #1;
        checks++; if (out_data[47:32] !== 16'h0001) begin failures++; $display("FAIL drain_first got=%h exp=0001", out_data[47:32]); end
        tick();
        checks++; if (out_data[47:32] !== 16'h0002) begin failures++; $display("FAIL drain_second got=%h exp=0002", out_data[47:32]); end
        tick();
        out_ready = 4'b0000;
        checks++; if (out_valid[2] !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", out_valid[2]); end
        checks++; if (out_data[47:32] !== 16'h0000) begin failures++; $display("FAIL drain_zero got=%h exp=0000", out_data[47:32]); end
    endtask

    task automatic test_full_pop_block;
        in_valid = 1'b1; in_sel = 2'd3;
        in_data = 16'h0031; tick();
        in_data = 16'h0032; tick();
        in_data = 16'h0033; out_ready = 4'b1000; #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fullpop_ready got=%b exp=0", in_ready); end
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL fullpop_drop got=%0d exp=2", drop_cnt); end
        checks++; if (occ[7:6] !== 2'd1) begin failures++; $display("FAIL fullpop_occ got=%0d exp=1", occ[7:6]); end
        checks++; if (out_data[63:48] !== 16'h0032) begin failures++; $display("FAIL fullpop_head got=%h exp=0032", out_data[63:48]); end
        out_ready = 4'b1000; tick(); out_ready = 4'b0000;
        checks++; if (out_valid[3] !== 1'b0) begin failures++; $display("FAIL fullpop_drain got=%b exp=0", out_valid[3]); end
    endtask

    task automatic test_concurrent;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h00AA; tick();
        in_data = 16'h00BB; out_ready = 4'b0010; tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        checks++; if (out_data[31:16] !== 16'h00BB) begin failures++; $display("FAIL conc_head got=%h exp=00bb", out_data[31:16]); end
        checks++; if (occ[3:2] !== 2'd1) begin failures++; $display("FAIL conc_occ got=%0d exp=1", occ[3:2]); end
        out_ready = 4'b0010; tick(); out_ready = 4'b0000;
        checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL conc_drain got=%b exp=0000", out_valid); end
    endtask

    task automatic test_empty_push_pop;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 16'h1234; out_ready = 4'b0001; tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        checks++; if (out_valid[0] !== 1'b1) begin failures++; $display("FAIL emptypp_valid got=%b exp=1", out_valid[0]); end
        checks++; if (out_data[15:0] !== 16'h1234) begin failures++; $display("FAIL emptypp_data got=%h exp=1234", out_data[15:0]); end
        checks++; if (occ[1:0] !== 2'd1) begin failures++; $display("FAIL emptypp_occ got=%0d exp=1", occ[1:0]); end
        out_ready = 4'b0001; tick(); out_ready = 4'b0000;
    endtask

    task automatic test_wrap;
        in_valid = 1'b1; in_sel = 2'd2;
        in_data = 16'h000A; tick();
        in_data = 16'h000B; tick();
        in_valid = 1'b0; out_ready = 4'b0100; tick();
        out_ready = 4'b0000; in_valid = 1'b1; in_data = 16'h000C; tick();
        in_valid = 1'b0;
        checks++; if (out_data[47:32] !== 16'h000B) begin failures++; $display("FAIL wrap_head1 got=%h exp=000b", out_data[47:32]); end
        checks++; if (occ[5:4] !== 2'd2) begin failures++; $display("FAIL wrap_occ got=%0d exp=2", occ[5:4]); end
        out_ready = 4'b0100; tick();
        checks++; if (out_data[47:32] !== 16'h000C) begin failures++; $display("FAIL wrap_head2 got=%h exp=000c", out_data[47:32]); end
        tick(); out_ready = 4'b0000;
        checks++; if (out_valid[2] !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b exp=0", out_valid[2]); end
    endtask

    task automatic test_ignore_invalid;
        in_valid = 1'b0; in_sel = 2'd3; in_data = 16'hDEAD; tick(); tick();
        checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL idle_valid got=%b exp=0000", out_valid); end
        checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL idle_drop got=%0d exp=2", drop_cnt); end
        checks++; if (occ !== 8'h00) begin failures++; $display("FAIL idle_occ got=%h exp=00", occ); end
    endtask

    task automatic test_mid_reset;
        in_valid = 1'b1;
        in_sel = 2'd1; in_data = 16'h0011; tick();
        in_sel = 2'd2; in_data = 16'h0021; tick();
        in_sel = 2'd3; in_data = 16'h0031; tick();
        in_sel = 2'd0; in_data = 16'h0001; tick();
        in_data = 16'h0002; tick();
        in_data = 16'h0003; tick(); tick(); tick();
        in_valid = 1'b0;
        checks++; if (drop_cnt !== 16'd5) begin failures++; $display("FAIL mr_pre_drop got=%0d exp=5", drop_cnt); end
        checks++; if (out_valid !== 4'b1111) begin failures++; $display("FAIL mr_pre_valid got=%b exp=1111", out_valid); end
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h00FF; out_ready = 4'b1111; tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
        checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL mr_valid got=%b exp=0000", out_valid); end
        checks++; if (occ !== 8'h00) begin failures++; $display("FAIL mr_occ got=%h exp=00", occ); end
        checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL mr_drop got=%0d exp=0", drop_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mr_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 64'h0) begin failures++; $display("FAIL mr_data got=%h exp=0", out_data); end
        tick();
        checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL mr_after got=%b exp=0000", out_valid); end
    endtask

    initial begin
        test_reset();
        test_route();
        test_fill();
        test_drain();
        test_full_pop_block();
        test_concurrent();
        test_empty_push_pop();
        test_wrap();
        test_ignore_invalid();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
